// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encodings used by both the TAP controller
// and the IR/DR block, instruction codes and the data-register select type.
package jtag_pkg;

    localparam logic [3:0] TAP_EXIT2_DR   = 4'h0;
    localparam logic [3:0] TAP_EXIT1_DR   = 4'h1;
    localparam logic [3:0] TAP_SHIFT_DR   = 4'h2;
    localparam logic [3:0] TAP_PAUSE_DR   = 4'h3;
    localparam logic [3:0] TAP_SELECT_IR  = 4'h4;
    localparam logic [3:0] TAP_UPDATE_DR  = 4'h5;
    localparam logic [3:0] TAP_CAPTURE_DR = 4'h6;
    localparam logic [3:0] TAP_SELECT_DR  = 4'h7;
    localparam logic [3:0] TAP_EXIT2_IR   = 4'h8;
    localparam logic [3:0] TAP_EXIT1_IR   = 4'h9;
    localparam logic [3:0] TAP_SHIFT_IR   = 4'hA;
    localparam logic [3:0] TAP_PAUSE_IR   = 4'hB;
    localparam logic [3:0] TAP_RTI        = 4'hC;
    localparam logic [3:0] TAP_UPDATE_IR  = 4'hD;
    localparam logic [3:0] TAP_CAPTURE_IR = 4'hE;
    localparam logic [3:0] TAP_TLR        = 4'hF;

    // Truncated to the IR width at the point of use; BYPASS is all ones.
    localparam logic [31:0] INSTR_BYPASS = 32'hFFFF_FFFF;
    localparam logic [31:0] INSTR_IDCODE = 32'h0000_0001;
    localparam logic [31:0] INSTR_USER   = 32'h0000_0002;

    typedef enum logic [1:0] {
        DR_BYPASS,
        DR_IDCODE,
        DR_USER
    } dr_sel_e;

endpackage

// File: rtl/jtag_shift_reg.sv
// Generic JTAG capture/shift register: parallel load on capture, LSB-first
// shift with tdi entering the MSB, hold otherwise.
module jtag_shift_reg #(
    parameter int WIDTH = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             capture_en,
    input  logic [WIDTH-1:0] capture_val,
    input  logic             shift_en,
    input  logic             tdi,
    output logic [WIDTH-1:0] q,
    output logic             so
);

    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_d;
    logic [WIDTH-1:0] shifted;

    if (WIDTH == 1) begin : g_single
        assign shifted = tdi;
    end else begin : g_multi
        assign shifted = {tdi, sh_q[WIDTH-1:1]};
    end

    always_comb begin
        sh_d = sh_q;
        if (capture_en) begin
            sh_d = capture_val;
        end else if (shift_en) begin
            sh_d = shifted;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q  = sh_q;
    assign so = sh_q[0];

endmodule

// File: rtl/jtag_ir_dr.sv
// JTAG instruction register plus BYPASS, IDCODE and USER data registers,
// sequenced by the TAP controller's state and driving tdo.
module jtag_ir_dr
    import jtag_pkg::*;
#(
    parameter int                    IR_WIDTH     = 4,
    parameter logic [31:0]           IDCODE_VALUE = 32'h1234_5679,
    parameter int                    USER_WIDTH   = 8,
    parameter logic [USER_WIDTH-1:0] USER_RESET   = '0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [3:0]            state,
    input  logic                  tdi,
    output logic                  tdo,
    output logic [IR_WIDTH-1:0]   ir,
    output logic [USER_WIDTH-1:0] user_dr,
    input  logic [USER_WIDTH-1:0] user_capture,
    output logic                  user_update
);

    localparam logic [IR_WIDTH-1:0] IR_BYPASS  = IR_WIDTH'(INSTR_BYPASS);
    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(INSTR_IDCODE);
    localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(INSTR_USER);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

    logic [IR_WIDTH-1:0]   ir_q, ir_d;
    logic [USER_WIDTH-1:0] user_dr_q, user_dr_d;
    logic                  user_update_q, user_update_d;

    logic [IR_WIDTH-1:0]   ir_sh;
    logic [USER_WIDTH-1:0] usr_sh;
    logic                  ir_so, byp_so, id_so, usr_so;
    logic                  byp_q_unused;
    logic [31:0]           id_q_unused;

    dr_sel_e sel;
    logic    cap_dr, shf_dr;

    // Selection follows the active instruction, never the IR shift stage.
    always_comb begin
        if (ir_q == IR_BYPASS) begin
            sel = DR_BYPASS;
        end else if (ir_q == IR_IDCODE) begin
            sel = DR_IDCODE;
        end else if (ir_q == IR_USER) begin
            sel = DR_USER;
        end else begin
            sel = DR_BYPASS;
        end
    end

    assign cap_dr = (state == TAP_CAPTURE_DR);
    assign shf_dr = (state == TAP_SHIFT_DR);

    jtag_shift_reg #(.WIDTH(IR_WIDTH)) u_ir_sh (
        .CLK         (CLK),
        .RESET       (RESET),
        .capture_en  (state == TAP_CAPTURE_IR),
        .capture_val (IR_CAPTURE),
        .shift_en    (state == TAP_SHIFT_IR),
        .tdi         (tdi),
        .q           (ir_sh),
        .so          (ir_so)
    );

    jtag_shift_reg #(.WIDTH(1)) u_byp_sh (
        .CLK         (CLK),
        .RESET       (RESET),
        .capture_en  (cap_dr && (sel == DR_BYPASS)),
        .capture_val (1'b0),
        .shift_en    (shf_dr && (sel == DR_BYPASS)),
        .tdi         (tdi),
        .q           (byp_q_unused),
        .so          (byp_so)
    );

    jtag_shift_reg #(.WIDTH(32)) u_id_sh (
        .CLK         (CLK),
        .RESET       (RESET),
        .capture_en  (cap_dr && (sel == DR_IDCODE)),
        .capture_val (IDCODE_VALUE),
        .shift_en    (shf_dr && (sel == DR_IDCODE)),
        .tdi         (tdi),
        .q           (id_q_unused),
        .so          (id_so)
    );

    jtag_shift_reg #(.WIDTH(USER_WIDTH)) u_usr_sh (
        .CLK         (CLK),
        .RESET       (RESET),
        .capture_en  (cap_dr && (sel == DR_USER)),
        .capture_val (user_capture),
        .shift_en    (shf_dr && (sel == DR_USER)),
        .tdi         (tdi),
        .q           (usr_sh),
        .so          (usr_so)
    );

    always_comb begin
        ir_d          = ir_q;
        user_dr_d     = user_dr_q;
        user_update_d = 1'b0;
        if (state == TAP_TLR) begin
            ir_d = IR_IDCODE;
        end else if (state == TAP_UPDATE_IR) begin
            ir_d = ir_sh;
        end
        if ((state == TAP_UPDATE_DR) && (sel == DR_USER)) begin
            user_dr_d     = usr_sh;
            user_update_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ir_q          <= IR_IDCODE;
            user_dr_q     <= USER_RESET;
            user_update_q <= 1'b0;
        end else begin
            ir_q          <= ir_d;
            user_dr_q     <= user_dr_d;
            user_update_q <= user_update_d;
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (state == TAP_SHIFT_IR) begin
            tdo = ir_so;
        end else if (state == TAP_SHIFT_DR) begin
            if (sel == DR_IDCODE) begin
                tdo = id_so;
            end else if (sel == DR_USER) begin
                tdo = usr_so;
            end else begin
                tdo = byp_so;
            end
        end
    end

    assign ir          = ir_q;
    assign user_dr     = user_dr_q;
    assign user_update = user_update_q;

endmodule

// File: tb/tb_jtag_ir_dr.sv
// Bench for jtag_ir_dr: directed scenarios plus a random state walk checked
// against an arithmetic model of the instruction and data registers.
module tb_jtag_ir_dr;

    localparam logic [3:0] S_EXIT2_DR = 4'h0, S_EXIT1_DR = 4'h1, S_SHIFT_DR = 4'h2;
    localparam logic [3:0] S_PAUSE_DR = 4'h3, S_UPDATE_DR = 4'h5, S_CAPTURE_DR = 4'h6;
    localparam logic [3:0] S_SHIFT_IR = 4'hA, S_RTI = 4'hC, S_UPDATE_IR = 4'hD;
    localparam logic [3:0] S_CAPTURE_IR = 4'hE, S_TLR = 4'hF;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [3:0] state = S_RTI;
    logic       tdi = 1'b0;
    logic       tdo;
    logic [3:0] ir;
    logic [7:0] user_dr;
    logic [7:0] user_capture = 8'h00;
    logic       user_update;

    int n_cmp = 0;
    int n_fail = 0;

    logic obs_tdo, exp_tdo;

    // Reference model: registers kept as plain integers, shifts done arithmetically.
    longint unsigned m_ir, m_ir_sh, m_byp, m_id, m_usr, m_user_dr;
    bit m_upd;

    jtag_ir_dr dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .state        (state),
        .tdi          (tdi),
        .tdo          (tdo),
        .ir           (ir),
        .user_dr      (user_dr),
        .user_capture (user_capture),
        .user_update  (user_update)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit (actual running, required finished)");
        $fatal(1);
    end

    function automatic int model_sel();
        if (m_ir == 1) return 1;
        if (m_ir == 2) return 2;
        return 0;
    endfunction

    function automatic logic model_tdo(input logic [3:0] st);
        int s;
        s = model_sel();
        if (st == S_SHIFT_IR) return logic'(m_ir_sh & 1);
        if (st == S_SHIFT_DR) begin
            if (s == 1) return logic'(m_id & 1);
            if (s == 2) return logic'(m_usr & 1);
            return logic'(m_byp & 1);
        end
        return 1'b0;
    endfunction

    task automatic model_step(input logic [3:0] st, input logic t, input logic r);
        int s;
        longint unsigned tv;
        s  = model_sel();
        tv = longint'(t);
        m_upd = 1'b0;
        if (r) begin
            m_ir = 1; m_ir_sh = 0; m_byp = 0; m_id = 0; m_usr = 0; m_user_dr = 0;
        end else begin
            case (st)
                S_TLR:        m_ir = 1;
                S_CAPTURE_IR: m_ir_sh = 1;
                S_SHIFT_IR:   m_ir_sh = (m_ir_sh >> 1) | (tv << 3);
                S_UPDATE_IR:  m_ir = m_ir_sh;
                S_CAPTURE_DR: begin
                    if (s == 1) m_id = 64'h1234_5679;
                    else if (s == 2) m_usr = longint'(user_capture);
                    else m_byp = 0;
                end
                S_SHIFT_DR: begin
                    if (s == 1) m_id = (m_id >> 1) | (tv << 31);
                    else if (s == 2) m_usr = (m_usr >> 1) | (tv << 7);
                    else m_byp = tv;
                end
                S_UPDATE_DR: begin
                    if (s == 2) begin
                        m_user_dr = m_usr;
                        m_upd = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One TCK cycle: drive on the falling edge, sample tdo mid-cycle, advance the model.
    task automatic apply(input logic [3:0] st, input logic t, input logic r);
        @(negedge CLK);
        state = st;
        tdi   = t;
        RESET = r;
        #1;
        obs_tdo = tdo;
        exp_tdo = model_tdo(st);
        @(posedge CLK);
        model_step(st, t, r);
        #1;
    endtask

    task automatic load_ir(input logic [3:0] v, output logic [3:0] bits);
        apply(S_CAPTURE_IR, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply(S_SHIFT_IR, v[i], 1'b0);
            bits[i] = obs_tdo;
        end
        apply(S_UPDATE_IR, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        apply(S_RTI, 1'b0, 1'b1);
        n_cmp++; if (ir !== 4'h1) begin n_fail++; $display("FAIL reset_ir: got %h want 1", ir); end
        n_cmp++; if (user_dr !== 8'h00) begin n_fail++; $display("FAIL reset_user_dr: got %h want 00", user_dr); end
        n_cmp++; if (user_update !== 1'b0) begin n_fail++; $display("FAIL reset_user_update: got %b want 0", user_update); end
        apply(S_RTI, 1'b1, 1'b0);
        n_cmp++; if (obs_tdo !== 1'b0) begin n_fail++; $display("FAIL reset_tdo: got %b want 0", obs_tdo); end
        n_cmp++; if (ir !== 4'h1) begin n_fail++; $display("FAIL reset_ir_hold: got %h want 1", ir); end
    endtask

    task automatic test_idcode();
        logic [31:0] word;
        apply(S_CAPTURE_DR, 1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            apply(S_SHIFT_DR, 1'b0, 1'b0);
            word[i] = obs_tdo;
        end
        n_cmp++; if (word[0] !== 1'b1) begin n_fail++; $display("FAIL idcode_first_bit: got %b want 1", word[0]); end
        n_cmp++; if (word !== 32'h1234_5679) begin n_fail++; $display("FAIL idcode_word: got %h want 12345679", word); end
        apply(S_SHIFT_DR, 1'b0, 1'b0);
        n_cmp++; if (obs_tdo !== 1'b0) begin n_fail++; $display("FAIL idcode_tdi_through: got %b want 0", obs_tdo); end
    endtask

    task automatic test_bypass();
        logic [3:0] bits, got;
        logic [3:0] pat;
        load_ir(4'hF, bits);
        n_cmp++; if (bits !== 4'b0001) begin n_fail++; $display("FAIL ir_capture_bits: got %b want 0001 (LSB first)", bits); end
        n_cmp++; if (ir !== 4'hF) begin n_fail++; $display("FAIL ir_load_f: got %h want f", ir); end
        pat = 4'b1101;
        apply(S_CAPTURE_DR, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply(S_SHIFT_DR, pat[i], 1'b0);
            got[i] = obs_tdo;
        end
        n_cmp++; if (got !== 4'b1010) begin n_fail++; $display("FAIL bypass_latency: got %b want 1010 (LSB first)", got); end
        load_ir(4'h5, bits);
        apply(S_CAPTURE_DR, 1'b0, 1'b0);
        apply(S_SHIFT_DR, 1'b1, 1'b0);
        got[0] = obs_tdo;
        apply(S_SHIFT_DR, 1'b1, 1'b0);
        got[1] = obs_tdo;
        n_cmp++; if (got[1:0] !== 2'b10) begin n_fail++; $display("FAIL unknown_instr_bypass: got %b want 10", got[1:0]); end
    endtask

    task automatic test_user();
        logic [3:0] bits;
        logic [7:0] got;
        logic [7:0] din;
        int early_pulse;
        din = 8'h5A;
        user_capture = 8'hC3;
        early_pulse = 0;
        load_ir(4'h2, bits);
        n_cmp++; if (ir !== 4'h2) begin n_fail++; $display("FAIL ir_load_user: got %h want 2", ir); end
        apply(S_CAPTURE_DR, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            apply(S_SHIFT_DR, din[i], 1'b0);
            got[i] = obs_tdo;
            if (user_update !== 1'b0) early_pulse++;
        end
        n_cmp++; if (got !== 8'hC3) begin n_fail++; $display("FAIL user_shift_out: got %h want c3", got); end
        n_cmp++; if (early_pulse != 0) begin n_fail++; $display("FAIL user_update_early: got %0d pulses want 0", early_pulse); end
        apply(S_UPDATE_DR, 1'b0, 1'b0);
        n_cmp++; if (user_dr !== 8'h5A) begin n_fail++; $display("FAIL user_dr_update: got %h want 5a", user_dr); end
        n_cmp++; if (user_update !== 1'b1) begin n_fail++; $display("FAIL user_update_pulse: got %b want 1", user_update); end
        apply(S_RTI, 1'b0, 1'b0);
        n_cmp++; if (user_update !== 1'b0) begin n_fail++; $display("FAIL user_update_width: got %b want 0", user_update); end
        n_cmp++; if (user_dr !== 8'h5A) begin n_fail++; $display("FAIL user_dr_hold: got %h want 5a", user_dr); end
    endtask

    task automatic test_pause();
        logic [7:0] din, got;
        logic [3:0] hold_st [5];
        int pulses;
        hold_st = '{S_EXIT1_DR, S_PAUSE_DR, S_PAUSE_DR, S_PAUSE_DR, S_EXIT2_DR};
        din = 8'hA5;
        apply(S_CAPTURE_DR, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) apply(S_SHIFT_DR, din[i], 1'b0);
        apply(S_UPDATE_DR, 1'b0, 1'b0);
        n_cmp++; if (user_dr !== 8'hA5) begin n_fail++; $display("FAIL pause_prefill: got %h want a5", user_dr); end
        din = 8'h5A;
        user_capture = 8'h3C;
        pulses = 0;
        apply(S_CAPTURE_DR, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply(S_SHIFT_DR, din[i], 1'b0);
            got[i] = obs_tdo;
        end
        for (int k = 0; k < 5; k++) begin
            apply(hold_st[k], 1'($urandom), 1'b0);
            if (user_update !== 1'b0) pulses++;
        end
        for (int i = 4; i < 8; i++) begin
            apply(S_SHIFT_DR, din[i], 1'b0);
            got[i] = obs_tdo;
        end
        n_cmp++; if (pulses != 0) begin n_fail++; $display("FAIL pause_no_update: got %0d pulses want 0", pulses); end
        n_cmp++; if (got !== 8'h3C) begin n_fail++; $display("FAIL pause_shift_out: got %h want 3c", got); end
        apply(S_UPDATE_DR, 1'b0, 1'b0);
        n_cmp++; if (user_dr !== 8'h5A) begin n_fail++; $display("FAIL pause_user_dr: got %h want 5a", user_dr); end
    endtask

    task automatic test_tlr_and_reset();
        logic [3:0]  bits;
        logic [31:0] word;
        logic [7:0]  ubits;
        apply(S_TLR, 1'b0, 1'b0);
        n_cmp++; if (ir !== 4'h1) begin n_fail++; $display("FAIL tlr_ir: got %h want 1", ir); end
        n_cmp++; if (user_dr !== 8'h5A) begin n_fail++; $display("FAIL tlr_user_dr: got %h want 5a", user_dr); end
        user_capture = 8'hFF;
        load_ir(4'h2, bits);
        apply(S_CAPTURE_DR, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) apply(S_SHIFT_DR, 1'b1, 1'b0);
        apply(S_SHIFT_DR, 1'b1, 1'b1);
        n_cmp++; if (user_update !== 1'b0) begin n_fail++; $display("FAIL midreset_update: got %b want 0", user_update); end
        n_cmp++; if (ir !== 4'h1 || user_dr !== 8'h00) begin
            n_fail++; $display("FAIL midreset_regs: got ir=%h user_dr=%h want ir=1 user_dr=00", ir, user_dr);
        end
        apply(S_UPDATE_DR, 1'b0, 1'b0);
        n_cmp++; if (user_update !== 1'b0) begin n_fail++; $display("FAIL midreset_update_after: got %b want 0", user_update); end
        for (int i = 0; i < 32; i++) begin
            apply(S_SHIFT_DR, 1'b0, 1'b0);
            word[i] = obs_tdo;
        end
        n_cmp++; if (word !== 32'h0) begin n_fail++; $display("FAIL midreset_id_sh: got %h want 0", word); end
        for (int i = 0; i < 4; i++) begin
            apply(S_SHIFT_IR, 1'b0, 1'b0);
            bits[i] = obs_tdo;
        end
        n_cmp++; if (bits !== 4'h0) begin n_fail++; $display("FAIL midreset_ir_sh: got %b want 0000", bits); end
        load_ir(4'h2, bits);
        for (int i = 0; i < 8; i++) begin
            apply(S_SHIFT_DR, 1'b0, 1'b0);
            ubits[i] = obs_tdo;
        end
        n_cmp++; if (ubits !== 8'h00) begin n_fail++; $display("FAIL midreset_usr_sh: got %h want 00", ubits); end
    endtask

    task automatic test_random();
        logic [3:0] st;
        logic       t, r;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 7) == 0) user_capture = 8'($urandom);
            r  = ($urandom_range(0, 49) == 0);
            st = 4'($urandom_range(0, 15));
            t  = 1'($urandom);
            apply(st, t, r);
            n_cmp++; if (obs_tdo !== exp_tdo) begin
                n_fail++; $display("FAIL rand_tdo c=%0d st=%h: got %b want %b", c, st, obs_tdo, exp_tdo);
            end
            n_cmp++; if (ir !== 4'(m_ir)) begin
                n_fail++; $display("FAIL rand_ir c=%0d: got %h want %h", c, ir, 4'(m_ir));
            end
            n_cmp++; if (user_dr !== 8'(m_user_dr)) begin
                n_fail++; $display("FAIL rand_user_dr c=%0d: got %h want %h", c, user_dr, 8'(m_user_dr));
            end
            n_cmp++; if (user_update !== m_upd) begin
                n_fail++; $display("FAIL rand_user_update c=%0d: got %b want %b", c, user_update, m_upd);
            end
        end
    endtask

    initial begin
        m_ir = 1; m_ir_sh = 0; m_byp = 0; m_id = 0; m_usr = 0; m_user_dr = 0; m_upd = 1'b0;
        test_reset();
        test_idcode();
        test_bypass();
        test_user();
        test_pause();
        test_tlr_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_ir_dr.md
Name: jtag_ir_dr

Overview:
Downstream companion to the team's JTAG TAP controller. It consumes the controller's 4-bit state and implements the instruction register plus three data registers: BYPASS, IDCODE and a USER read/write register. It captures, shifts and updates these registers in lock-step with the TAP state and drives `tdo`. It sits between the TAP controller and core-side debug logic.

Parameters:
- IR_WIDTH, 4: instruction register width (>=2).
- IDCODE_VALUE, 32'h1234_5679: value captured into the IDCODE DR; bit 0 must be 1.
- USER_WIDTH, 8: USER data register width (>=1).
- USER_RESET, 0: reset value of `user_dr`.

Ports:
- CLK  in  1  TCK-domain clock, same clock as the TAP controller.
- RESET  in  1  synchronous, active-high reset.
- state  in  4  current TAP state, using the TAP encoding (TLR=15, RTI=12, CAPTURE_DR=6, SHIFT_DR=2, UPDATE_DR=5, CAPTURE_IR=14, SHIFT_IR=10, UPDATE_IR=13; all others are hold states).
- tdi  in  1  serial data in.
- tdo  out  1  serial data out.
- ir  out  IR_WIDTH  active instruction.
- user_dr  out  USER_WIDTH  last USER value updated from JTAG.
- user_capture  in  USER_WIDTH  core value loaded on CAPTURE_DR when USER is selected.
- user_update  out  1  one-cycle pulse when `user_dr` is written.

Behaviour:
Instruction encoding:
- BYPASS = all ones.
- IDCODE = 1.
- USER = 2.
- Any other code selects BYPASS.

Internal registers:
- `ir_sh`, IR_WIDTH bits.
- `byp_sh`, 1 bit.
- `id_sh`, 32 bits.
- `usr_sh`, USER_WIDTH bits.

Reset and clocking:
- When RESET=1 at a CLK edge: `ir`=IDCODE, `ir_sh`=0, `byp_sh`=0, `id_sh`=0, `usr_sh`=0, `user_dr`=USER_RESET, `user_update`=0. RESET overrides every state action.
- All actions below happen on the CLK posedge and are qualified by the sampled `state` value.

Per-state actions:
- TEST_LOGIC_RESET: `ir` <= IDCODE. Shift registers hold. `user_dr` holds.
- CAPTURE_IR: `ir_sh` <= {0…0,2'b01}, i.e. the LSBs are 01 per IEEE 1149.1.
- SHIFT_IR: `ir_sh` <= {tdi, ir_sh[IR_WIDTH-1:1]}, shifting LSB first.
- UPDATE_IR: `ir` <= `ir_sh`.
- CAPTURE_DR, selected register only:
  - BYPASS: `byp_sh` <= 0.
  - IDCODE: `id_sh` <= IDCODE_VALUE.
  - USER: `usr_sh` <= `user_capture`.
- SHIFT_DR: only the selected register shifts, with `tdi` into the MSB and the LSB leaving first. Unselected registers hold.
- UPDATE_DR with USER selected: `user_dr` <= `usr_sh` and `user_update`=1 for exactly the next cycle. UPDATE_DR with IDCODE or BYPASS selected: no effect.
- `user_update` is registered and is 0 in every cycle not directly following a qualifying UPDATE_DR.

`tdo` (combinational):
- state==SHIFT_IR: `ir_sh[0]`.
- state==SHIFT_DR: bit 0 of the selected DR shift register.
- Otherwise: 0.

Selection and latencies:
- The selected DR is decoded from `ir`, not `ir_sh`. An instruction change therefore takes effect from the cycle after UPDATE_IR.
- BYPASS gives 1-cycle tdi->tdo latency, measured in SHIFT_DR cycles.
- IDCODE shifts out 32 bits, LSB first. After 32 shifts, the captured `tdi` bits appear at `tdo`.
- A state of PAUSE/EXIT mid-shift holds all registers. Shifting resumes exactly where it left off.
- Illegal or unlisted state codes are treated as hold.

Decomposition:
- Shared package `jtag_pkg`:
  - TAP state localparams, the 16 encodings moved out of the TAP controller so both blocks share them.
  - Instruction code constants: INSTR_BYPASS, INSTR_IDCODE, INSTR_USER.
- One natural sub-module, `jtag_shift_reg #(WIDTH)`, instantiated four times (IR, BYPASS, IDCODE, USER).
  - Inputs: capture_en, capture_val, shift_en, tdi.
  - Outputs: q, so[bit0].
- Top-level logic: instruction decode, the update registers, and the `tdo` mux.

Test Plan:
1. Assert RESET for 1 cycle -> `ir`=4'h1, `user_dr`=8'h00, `user_update`=0, `tdo`=0.
2. With the default IDCODE selected: state CAPTURE_DR, then 32×SHIFT_DR with `tdi`=0 -> `tdo` sequence, LSB first, equals 32'h1234_5679; the first `tdo` bit is 1.
3. Load IR=4'hF (CAPTURE_IR, 4×SHIFT_IR with `tdi`=1, UPDATE_IR). Check that the `tdo` bits during the IR shift are 1,0,0,0. Then CAPTURE_DR followed by SHIFT_DR with `tdi` pattern 1,0,1,1 -> `tdo` = 0,1,0,1.
4. Load IR=4'h2 with `user_capture`=8'hC3. Then CAPTURE_DR, 8×SHIFT_DR with `tdi` bits of 8'h5A LSB first, then UPDATE_DR -> `tdo` shifts out 8'hC3 LSB first; `user_dr`=8'h5A; `user_update` high exactly 1 cycle.
5. USER shift interrupted after 4 bits by EXIT1_DR, 3×PAUSE_DR and EXIT2_DR, then 4 more SHIFT_DR and UPDATE_DR -> `user_dr` equals the same 8'h5A as the uninterrupted run.
6. With `ir`=4'h2, hold state=TEST_LOGIC_RESET for 1 cycle -> `ir`=4'h1 while `user_dr` is unchanged. Separately, assert RESET mid-SHIFT_DR -> all shift registers are 0 and `user_update` stays 0.
